// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider producing one quotient bit per clock.
// Trial subtraction runs through a chain of 4-bit carry-lookahead add/sub slices.

module seq_divider_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] bx;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        bx   = b ^ {4{sub}};
        g    = a & bx;
        p    = a ^ bx;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one shift/trial-subtract per cycle, WIDTH cycles
// FIX   | sign correction, results loaded
// DONE  | done pulse raised on exit, busy dropped
module seq_divider #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam int NS = WIDTH / 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] dmag;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic [NS:0]      carry;
    logic             trial_ok;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign a_neg   = SIGNED && dividend[WIDTH-1];
    assign b_neg   = SIGNED && divisor[WIDTH-1];
    assign a_mag   = a_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign b_mag   = b_neg ? (~divisor + WIDTH'(1)) : divisor;
    assign shifted = {prem, work_q[WIDTH-1]};
    assign carry[0] = 1'b1;

    // Low WIDTH bits subtract through the slices; the extra MSB of the shifted
    // remainder absorbs any final borrow, so the trial is non-negative iff
    // that bit is set or the chain produced no borrow.
    for (genvar i = 0; i < NS; i++) begin : g_slice
        seq_divider_cla4 u_slice (
            .a    (shifted[4*i +: 4]),
            .b    (dmag[4*i +: 4]),
            .sub  (1'b1),
            .cin  (carry[i]),
            .sum  (diff[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    assign trial_ok = shifted[WIDTH] | carry[NS];
    assign q_fix    = q_neg ? (~work_q + WIDTH'(1)) : work_q;
    assign r_fix    = r_neg ? (~prem + WIDTH'(1)) : prem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            prem        <= '0;
            work_q      <= '0;
            dmag        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        prem        <= '0;
                        dmag        <= b_mag;
                        q_neg       <= a_neg ^ b_neg;
                        r_neg       <= a_neg;
                        cnt         <= CW'(WIDTH - 1);
                        // The raw dividend rides in work_q so it can be returned as the remainder.
                        if (divisor == '0) begin
                            dz     <= 1'b1;
                            work_q <= dividend;
                            state  <= S_DONE;
                        end else begin
                            dz     <= 1'b0;
                            work_q <= a_mag;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    work_q <= {work_q[WIDTH-2:0], trial_ok};
                    prem   <= trial_ok ? diff : shifted[WIDTH-1:0];
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= work_q;
                        div_by_zero <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider, unsigned and signed instances
// sharing the same stimulus.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] q_u, r_u, q_s, r_s;
    logic        busy_u, done_u, dz_u, busy_s, done_s, dz_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(16), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q_u), .remainder(r_u), .busy(busy_u), .done(done_u), .div_by_zero(dz_u)
    );

    seq_divider #(.WIDTH(16), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q_s), .remainder(r_s), .busy(busy_s), .done(done_s), .div_by_zero(dz_s)
    );

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts at the first sample after the accepting edge; k counts edges since accept.
    task automatic wait_done(output int k, output bit busy_ok);
        k = 0;
        busy_ok = 1'b1;
        while (done_u !== 1'b1 && k < 60) begin
            if (busy_u !== 1'b1 || busy_s !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        if (busy_u !== 1'b0 || done_s !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        dividend = 16'd9;
        divisor = 16'd3;
        repeat (3) @(negedge clk);
        checks++;
        if ({q_u, r_u, busy_u, done_u, dz_u} !== 35'd0) begin
            errors++;
            $display("FAIL reset_u: got q=%h r=%h b=%b d=%b z=%b, want all 0", q_u, r_u, busy_u, done_u, dz_u);
        end
        checks++;
        if ({q_s, r_s, busy_s, done_s, dz_s} !== 35'd0) begin
            errors++;
            $display("FAIL reset_s: got q=%h r=%h b=%b d=%b z=%b, want all 0", q_s, r_s, busy_s, done_s, dz_s);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int  k;
        bit  bok;
        issue(16'd100, 16'd7);
        wait_done(k, bok);
        checks++;
        if (k != 18) begin errors++; $display("FAIL basic_latency: got %0d, want 18", k); end
        checks++;
        if (!bok) begin errors++; $display("FAIL basic_busy: busy/done profile wrong, want busy high until done"); end
        checks++;
        if (q_u !== 16'd14 || r_u !== 16'd2 || dz_u !== 1'b0) begin
            errors++; $display("FAIL basic_u: got q=%0d r=%0d z=%b, want 14 r 2 z 0", q_u, r_u, dz_u);
        end
        checks++;
        if (q_s !== 16'd14 || r_s !== 16'd2) begin
            errors++; $display("FAIL basic_s: got q=%0d r=%0d, want 14 r 2", q_s, r_s);
        end
        @(negedge clk);
        checks++;
        if (done_u !== 1'b0 || q_u !== 16'd14) begin
            errors++; $display("FAIL basic_pulse: got done=%b q=%0d, want done 0 q 14", done_u, q_u);
        end
    endtask

    task automatic test_signed;
        int k;
        bit bok;
        issue(16'hFFF9, 16'd2);
        wait_done(k, bok);
        checks++;
        if (q_s !== 16'hFFFD || r_s !== 16'hFFFF) begin
            errors++; $display("FAIL signed_m7_2: got q=%h r=%h, want fffd r ffff", q_s, r_s);
        end
        checks++;
        if (q_u !== 16'h7FFC || r_u !== 16'h0001) begin
            errors++; $display("FAIL unsigned_fff9_2: got q=%h r=%h, want 7ffc r 0001", q_u, r_u);
        end
        issue(16'h0007, 16'hFFFE);
        wait_done(k, bok);
        checks++;
        if (q_s !== 16'hFFFD || r_s !== 16'h0001) begin
            errors++; $display("FAIL signed_7_m2: got q=%h r=%h, want fffd r 0001", q_s, r_s);
        end
        checks++;
        if (q_u !== 16'h0000 || r_u !== 16'h0007) begin
            errors++; $display("FAIL unsigned_7_fffe: got q=%h r=%h, want 0000 r 0007", q_u, r_u);
        end
    endtask

    task automatic test_overflow;
        int k;
        bit bok;
        issue(16'h8000, 16'hFFFF);
        wait_done(k, bok);
        checks++;
        if (q_s !== 16'h8000 || r_s !== 16'h0000 || dz_s !== 1'b0) begin
            errors++; $display("FAIL signed_ovf: got q=%h r=%h z=%b, want 8000 r 0000 z 0", q_s, r_s, dz_s);
        end
        checks++;
        if (q_u !== 16'h0000 || r_u !== 16'h8000) begin
            errors++; $display("FAIL unsigned_8000_ffff: got q=%h r=%h, want 0000 r 8000", q_u, r_u);
        end
        issue(16'hFFFF, 16'h0001);
        wait_done(k, bok);
        checks++;
        if (q_u !== 16'hFFFF || r_u !== 16'h0000) begin
            errors++; $display("FAIL unsigned_ffff_1: got q=%h r=%h, want ffff r 0000", q_u, r_u);
        end
        checks++;
        if (q_s !== 16'hFFFF || r_s !== 16'h0000) begin
            errors++; $display("FAIL signed_m1_1: got q=%h r=%h, want ffff r 0000", q_s, r_s);
        end
    endtask

    task automatic test_div_zero;
        int k;
        bit bok;
        issue(16'd1234, 16'd0);
        wait_done(k, bok);
        checks++;
        if (k != 1) begin errors++; $display("FAIL dz_latency: got %0d, want 1", k); end
        checks++;
        if (q_u !== 16'hFFFF || r_u !== 16'd1234 || dz_u !== 1'b1) begin
            errors++; $display("FAIL dz_u: got q=%h r=%0d z=%b, want ffff r 1234 z 1", q_u, r_u, dz_u);
        end
        checks++;
        if (q_s !== 16'hFFFF || r_s !== 16'd1234 || dz_s !== 1'b1) begin
            errors++; $display("FAIL dz_s: got q=%h r=%0d z=%b, want ffff r 1234 z 1", q_s, r_s, dz_s);
        end
        issue(16'd10, 16'd3);
        checks++;
        if (dz_u !== 1'b0 || q_u !== 16'hFFFF) begin
            errors++; $display("FAIL dz_clear: got z=%b q=%h, want z 0 q ffff held", dz_u, q_u);
        end
        wait_done(k, bok);
        checks++;
        if (q_u !== 16'd3 || r_u !== 16'd1 || dz_u !== 1'b0 || k != 18) begin
            errors++; $display("FAIL after_dz: got q=%0d r=%0d z=%b lat=%0d, want 3 r 1 z 0 lat 18", q_u, r_u, dz_u, k);
        end
    endtask

    task automatic test_ignore_start;
        int k;
        bit bok;
        issue(16'd100, 16'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        dividend = 16'd50;
        divisor = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bok);
        checks++;
        if (q_u !== 16'd14 || r_u !== 16'd2 || k != 13) begin
            errors++; $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want 14 r 2 lat 13", q_u, r_u, k);
        end
        @(negedge clk);
        checks++;
        if (busy_u !== 1'b0) begin
            errors++; $display("FAIL ignore_idle: got busy=%b, want 0", busy_u);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        int k2;
        bit seen;
        bit bok;
        @(negedge clk);
        start = 1'b1;
        dividend = 16'd100;
        divisor = 16'd7;
        @(negedge clk);
        k = 0;
        seen = 1'b0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (done_u === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (q_u !== 16'd14 || r_u !== 16'd2) begin
                    errors++; $display("FAIL b2b_first: got q=%0d r=%0d, want 14 r 2", q_u, r_u);
                end
            end else if (seen && busy_u === 1'b1) begin
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (k != 19) begin errors++; $display("FAIL b2b_spacing: got %0d, want 19", k); end
        wait_done(k2, bok);
        checks++;
        if (k2 != 18 || q_u !== 16'd14 || r_u !== 16'd2) begin
            errors++; $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d, want 14 r 2 lat 18", q_u, r_u, k2);
        end
    endtask

    task automatic test_reset_abort;
        int k;
        bit bok;
        bit seen;
        issue(16'd1000, 16'd3);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({q_u, r_u, busy_u, done_u, dz_u} !== 35'd0) begin
            errors++; $display("FAIL abort_zero: got q=%h r=%h b=%b d=%b z=%b, want all 0", q_u, r_u, busy_u, done_u, dz_u);
        end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done_u === 1'b1 || done_s === 1'b1 || q_u !== 16'd0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_nodone: got done/result after abort, want none"); end
        issue(16'd1000, 16'd3);
        wait_done(k, bok);
        checks++;
        if (q_u !== 16'd333 || r_u !== 16'd1 || q_s !== 16'd333 || r_s !== 16'd1) begin
            errors++; $display("FAIL abort_rerun: got u %0d r %0d s %0d r %0d, want 333 r 1", q_u, r_u, q_s, r_s);
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b, eq_u, er_u, eq_s, er_s;
        int          sa, sb, qi, ri, k, mode;
        bit          bok;
        longint      recon;
        for (int n = 0; n < 1500; n++) begin
            mode = $urandom_range(0, 5);
            a = 16'($urandom);
            b = 16'($urandom);
            case (mode)
                0: b = 16'd1;
                1: begin a = 16'd0; b = b | 16'd1; end
                2: begin b = b | 16'd2; a = 16'($urandom_range(0, int'(b) - 1)); end
                3: b = 16'd0;
                5: begin
                    b = 16'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) b = -b;
                    if ($urandom_range(0, 3) == 0) a = 16'h8000;
                end
                default: ;
            endcase
            if (b == 16'd0) begin
                eq_u = 16'hFFFF; er_u = a; eq_s = 16'hFFFF; er_s = a;
            end else begin
                eq_u = a / b;
                er_u = a % b;
                sa = $signed(a);
                sb = $signed(b);
                qi = sa / sb;
                ri = sa % sb;
                eq_s = qi[15:0];
                er_s = ri[15:0];
            end
            issue(a, b);
            wait_done(k, bok);
            checks++;
            if (k != ((b == 16'd0) ? 1 : 18) || !bok) begin
                errors++; $display("FAIL rand_timing: %h/%h got lat=%0d busy_ok=%b", a, b, k, bok);
            end
            checks++;
            if (q_u !== eq_u || r_u !== er_u || dz_u !== (b == 16'd0)) begin
                errors++; $display("FAIL rand_u: %h/%h got q=%h r=%h z=%b, want q=%h r=%h", a, b, q_u, r_u, dz_u, eq_u, er_u);
            end
            checks++;
            if (q_s !== eq_s || r_s !== er_s || dz_s !== (b == 16'd0)) begin
                errors++; $display("FAIL rand_s: %h/%h got q=%h r=%h z=%b, want q=%h r=%h", a, b, q_s, r_s, dz_s, eq_s, er_s);
            end
            if (b != 16'd0) begin
                recon = longint'(q_u) * longint'(b) + longint'(r_u);
                checks++;
                if (recon != longint'(a) || r_u >= b) begin
                    errors++; $display("FAIL rand_invariant: %h/%h got q*d+r=%0d r=%h, want %0d and r<d", a, b, recon, r_u, a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
